reg_sweep_ctrl: RTL
===================

REG_SWEEP_CTRL -- requirements
Module: reg_sweep_ctrl

Interface
REQ-001 Parameter: NUM_REGS, default 16, number of register-file entries swept (legal 2..16); last index = NUM_REGS-1.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: clear  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  sampled in IDLE only; begins a sweep.
REQ-005 Port: mode  in  1  sampled with start; 0 = dump, 1 = fill.
REQ-006 Port: fill_value  in  16  sampled with start; base data for fill.
REQ-007 Port: read_reg_1  out  4  register-file read address.
REQ-008 Port: reg_1_data  in  16  register-file read data, combinational from read_reg_1.
REQ-009 Port: reg_write  out  1  register-file write enable.
REQ-010 Port: write_reg_no  out  4  register-file write address.
REQ-011 Port: input_data  out  16  register-file write data.
REQ-012 Port: out_valid  out  1  dump stream data valid.
REQ-013 Port: out_ready  in  1  dump stream consumer ready.
REQ-014 Port: out_data  out  16  dumped register value.
REQ-015 Port: out_reg_no  out  4  index of out_data.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: done  out  1  one-cycle pulse at sweep completion.

Function
REQ-018 States IDLE, DUMP_RD, DUMP_OUT, FILL, DONE; 4-bit index idx; all outputs registered except busy (decoded from state).
REQ-019 IDLE: start=1 -> idx<=0, latch mode/fill_value; mode=0 -> DUMP_RD, mode=1 -> FILL; start=0 -> stay.
REQ-020 DUMP_RD (one cycle): read_reg_1=idx; at edge out_data<=reg_1_data, out_reg_no<=idx, out_valid<=1, -> DUMP_OUT.
REQ-021 DUMP_OUT: out_data, out_reg_no, out_valid held stable while out_ready=0.
REQ-022 DUMP_OUT with out_ready=1: transfer; out_valid<=0; idx<NUM_REGS-1 -> idx+1, DUMP_RD; idx=NUM_REGS-1 -> DONE.
REQ-023 Dump throughput: one word per 2 cycles with out_ready tied high; total 2*NUM_REGS cycles from start to DONE.
REQ-024 FILL: reg_write=1, write_reg_no=idx, input_data per REQ-033; one register per cycle; after idx=NUM_REGS-1 write -> DONE; reg_write=0 in all other states.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE; start in DONE ignored.
REQ-026 start, mode, fill_value changes while busy=1 ignored; no sweep restart or abort.
REQ-027 read_reg_1 holds last driven value outside DUMP_RD; write_reg_no/input_data hold last value when reg_write=0.
REQ-028 idx never exceeds NUM_REGS-1; no wrap-around into a second sweep.

Reset
REQ-029 clear=1 forces immediately, independent of clk: state IDLE, idx 0, busy 0, done 0, reg_write 0, out_valid 0.
REQ-030 clear=1 forces read_reg_1, write_reg_no, out_reg_no to 0 and input_data, out_data to 16'h0000.
REQ-031 clear mid-sweep abandons it: no done pulse, no further writes; partially dumped/filled entries not restored.
REQ-032 First start accepted on first rising edge after clear deasserts.

Configuration
REQ-033 Macro SWEEP_FILL_INC_EN: defined -> FILL writes fill_value+idx (16-bit, modulo 2^16); undefined -> FILL writes fill_value to every entry; dump unaffected.

Verification
REQ-034 Fill: start=1, mode=1, fill_value=16'hA5A5, macro undefined -> reg_write high 16 consecutive cycles, write_reg_no 0..15, all data A5A5, done pulse next cycle.
REQ-035 Fill inc: macro defined, fill_value=16'hFFFE -> entries 0..3 written FFFE, FFFF, 0000, 0001; entry 15 = 000D.
REQ-036 Dump, ready high: regfile entry k preloaded k*16'h0101 -> out_data 0000, 0101 ... 0F0F with out_reg_no 0..15, done at cycle 33 after start.
REQ-037 Backpressure: out_ready low 5 cycles at idx=3 -> out_valid, out_data=0303, out_reg_no=3 held stable; resumes at 4 after ready.
REQ-038 Abort: clear pulsed during FILL at idx=7 -> reg_write drops before next edge, entries 8..15 unchanged, no done; new start succeeds.
REQ-039 Ignore: start pulsed with mode=1 during dump -> dump completes normally, no reg_write asserted.

Source files
------------

// File: rtl/reg_sweep_ctrl.sv
// Register-file sweep controller: dumps every entry onto a ready/valid stream or fills every entry.
// Build option SWEEP_FILL_INC_EN: fill writes fill_value + index instead of a constant fill_value.
module reg_sweep_ctrl #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] fill_value,
    output logic [3:0]  read_reg_1,
    input  logic [15:0] reg_1_data,
    output logic        reg_write,
    output logic [3:0]  write_reg_no,
    output logic [15:0] input_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_reg_no,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

`ifdef SWEEP_FILL_INC_EN
    localparam bit FILL_INC = 1'b1;
`else
    localparam bit FILL_INC = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        DUMP_RD,
        DUMP_OUT,
        FILL,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [3:0]  idx_inc;
    logic [15:0] fill_q, fill_q_nxt;

    logic [3:0]  read_reg_1_nxt;
    logic        reg_write_nxt;
    logic [3:0]  write_reg_no_nxt;
    logic [15:0] input_data_nxt;
    logic        out_valid_nxt;
    logic [15:0] out_data_nxt;
    logic [3:0]  out_reg_no_nxt;
    logic        done_nxt;

    function automatic logic [15:0] fill_word(input logic [15:0] base, input logic [3:0] i);
        return FILL_INC ? (base + {12'd0, i}) : base;
    endfunction

    assign idx_inc = idx + 4'd1;
    assign busy    = (state != IDLE);

    // Outputs are registered from next-state values so they are valid in the same cycle the state is.
    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        fill_q_nxt       = fill_q;
        read_reg_1_nxt   = read_reg_1;
        reg_write_nxt    = 1'b0;
        write_reg_no_nxt = write_reg_no;
        input_data_nxt   = input_data;
        out_valid_nxt    = out_valid;
        out_data_nxt     = out_data;
        out_reg_no_nxt   = out_reg_no;
        done_nxt         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt    = '0;
                    fill_q_nxt = fill_value;
                    if (mode) begin
                        state_nxt        = FILL;
                        reg_write_nxt    = 1'b1;
                        write_reg_no_nxt = '0;
                        input_data_nxt   = fill_word(fill_value, 4'd0);
                    end else begin
                        state_nxt      = DUMP_RD;
                        read_reg_1_nxt = '0;
                    end
                end
            end

            DUMP_RD: begin
                out_data_nxt   = reg_1_data;
                out_reg_no_nxt = idx;
                out_valid_nxt  = 1'b1;
                state_nxt      = DUMP_OUT;
            end

            DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt        = idx_inc;
                        read_reg_1_nxt = idx_inc;
                        state_nxt      = DUMP_RD;
                    end
                end
            end

            FILL: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt          = idx_inc;
                    reg_write_nxt    = 1'b1;
                    write_reg_no_nxt = idx_inc;
                    input_data_nxt   = fill_word(fill_q, idx_inc);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            idx          <= '0;
            fill_q       <= '0;
            read_reg_1   <= '0;
            reg_write    <= 1'b0;
            write_reg_no <= '0;
            input_data   <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_reg_no   <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            fill_q       <= fill_q_nxt;
            read_reg_1   <= read_reg_1_nxt;
            reg_write    <= reg_write_nxt;
            write_reg_no <= write_reg_no_nxt;
            input_data   <= input_data_nxt;
            out_valid    <= out_valid_nxt;
            out_data     <= out_data_nxt;
            out_reg_no   <= out_reg_no_nxt;
            done         <= done_nxt;
        end
    end

endmodule
